zero_count_pattern_gen: RTL

- Inverse of the team's combinational zero-counter.
- Accepts a requested zero count over a valid/ready handshake and builds an N-bit word containing exactly that many zeros.
- Presents the word in parallel, then streams it out bit-serially, LSB first, under a valid/ready handshake.
- Serves as stimulus source and loopback partner for zero/one counting blocks.

---
 rtl/zero_count_pattern_gen_pkg.sv | 31 +++
 rtl/zero_count_pattern_gen_if.sv | 31 +++
 rtl/zero_count_pattern_gen_serializer.sv | 48 ++++
 rtl/zero_count_pattern_gen.sv | 113 +++++++++++
 4 files changed

// File: rtl/zero_count_pattern_gen_pkg.sv
// Shared definitions for the zero-count pattern generator: FSM encoding,
// count-width derivation and the zero-mask builder.
package zcpg_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    localparam int unsigned MAX_N = 64;

    function automatic int unsigned cw_of(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    // Callers truncate the result to their own word width; k must already be <= n.
    function automatic logic [MAX_N-1:0] mask_of(input int unsigned n,
                                                 input int unsigned k,
                                                 input logic        zero_low);
        logic [MAX_N-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MAX_N; i++) begin
            if (i < n) begin
                if (zero_low) m[i] = (i >= k);
                else          m[i] = (i < (n - k));
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/zero_count_pattern_gen_if.sv
// Request, parallel-word and serial-stream bundle of the zero-count pattern generator.
// Handshakes: a beat transfers on a rising clk edge where valid && ready; valid
// never waits on ready, and the sender holds its payload stable until transfer.
interface zcpg_if #(
    parameter int unsigned N  = 8,
    parameter int unsigned CW = zcpg_pkg::cw_of(N)
);
    logic             req_valid;
    logic             req_ready;
    logic [CW-1:0]    req_count;
    logic [N-1:0]     word_out;
    logic             word_valid;
    logic             ser_valid;
    logic             ser_ready;
    logic             ser_data;
    logic             ser_last;
    logic             chk_err;
    zcpg_pkg::state_e dbg_state;

    modport master (
        output req_valid, req_count, ser_ready,
        input  req_ready, word_out, word_valid, ser_valid, ser_data, ser_last,
               chk_err, dbg_state
    );

    modport slave (
        input  req_valid, req_count, ser_ready,
        output req_ready, word_out, word_valid, ser_valid, ser_data, ser_last,
               chk_err, dbg_state
    );
endinterface

// File: rtl/zero_count_pattern_gen_serializer.sv
// LSB-first shift register with beat index; loaded by the top FSM and
// advanced on every accepted serial beat.
module zcpg_serializer #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [N-1:0] load_data_i,
    input  logic         active_i,
    input  logic         ser_ready_i,
    output logic         ser_data_o,
    output logic         ser_last_o,
    output logic         beat_o
);
    localparam int unsigned IW = $clog2(N);

    logic [N-1:0]  shreg_q, shreg_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          at_last;

    assign beat_o     = active_i && ser_ready_i;
    assign at_last    = (idx_q == IW'(N - 1));
    assign ser_data_o = active_i && shreg_q[0];
    assign ser_last_o = active_i && at_last;

    always_comb begin
        shreg_d = shreg_q;
        idx_d   = idx_q;
        if (load_i) begin
            shreg_d = load_data_i;
            idx_d   = '0;
        end else if (beat_o) begin
            shreg_d = shreg_q >> 1;
            idx_d   = at_last ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q <= '0;
            idx_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
        end
    end
endmodule

// File: rtl/zero_count_pattern_gen.sv
// Builds an N-bit word holding exactly k zeros and streams it LSB first.
// Define ZCPG_CHECK_EN to add the sticky zero-count self-check behind chk_err.
module zero_count_pattern_gen
    import zcpg_pkg::*;
#(
    parameter int unsigned N        = 8,
    parameter int unsigned ZERO_LOW = 1,
    parameter int unsigned CW       = cw_of(N)
) (
    input  logic clk,
    input  logic rst,
    zcpg_if.slave bus
);
    state_e        state_q, state_d;
    logic          init_q;
    logic          req_ready_c, ser_active;
    logic          accept, beat, last_beat;
    logic          ser_data, ser_last;
    logic [CW-1:0] k_sat;
    logic [N-1:0]  mask;
    logic [N-1:0]  word_q, word_d;
    logic          word_valid_q;

    assign accept    = bus.req_valid && req_ready_c;
    assign last_beat = beat && ser_last;
    assign k_sat     = (bus.req_count > CW'(N)) ? CW'(N) : bus.req_count;
    assign mask      = N'(mask_of(N, 32'(k_sat), ZERO_LOW != 0));
    assign word_d    = accept ? mask : word_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            init_q       <= 1'b0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            init_q       <= 1'b1;
            word_q       <= word_d;
            word_valid_q <= accept;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept)    state_d = ST_SHIFT;
            ST_SHIFT: if (last_beat) state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    // init_q keeps req_ready low until the first edge after reset release.
    always_comb begin
        req_ready_c    = init_q && (state_q == ST_IDLE);
        ser_active     = (state_q == ST_SHIFT);
        bus.req_ready  = req_ready_c;
        bus.ser_valid  = ser_active;
        bus.ser_data   = ser_data;
        bus.ser_last   = ser_last;
        bus.word_out   = word_q;
        bus.word_valid = word_valid_q;
        bus.dbg_state  = state_q;
    end

    zcpg_serializer #(.N(N)) u_ser (
        .clk         (clk),
        .rst         (rst),
        .load_i      (accept),
        .load_data_i (mask),
        .active_i    (ser_active),
        .ser_ready_i (bus.ser_ready),
        .ser_data_o  (ser_data),
        .ser_last_o  (ser_last),
        .beat_o      (beat)
    );

`ifdef ZCPG_CHECK_EN
    logic [CW-1:0] zcnt_q, zcnt_d, kq_q, kq_d, zinc;
    logic          err_q, err_d;

    assign zinc = zcnt_q + CW'(!ser_data);

    always_comb begin
        zcnt_d = zcnt_q;
        kq_d   = kq_q;
        err_d  = err_q;
        if (accept) begin
            zcnt_d = '0;
            kq_d   = k_sat;
        end else if (beat) begin
            zcnt_d = zinc;
            if (ser_last && (zinc != kq_q)) err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zcnt_q <= '0;
            kq_q   <= '0;
            err_q  <= 1'b0;
        end else begin
            zcnt_q <= zcnt_d;
            kq_q   <= kq_d;
            err_q  <= err_d;
        end
    end

    assign bus.chk_err = err_q;
`else
    assign bus.chk_err = 1'b0;
`endif
endmodule
